ibus_responder: RTL and testbench

IBUS_RESPONDER -- requirements
Module: ibus_responder

---
 rtl/ibus_responder_pkg.sv | 32 +++
 rtl/ibus_responder.sv | 157 +++++++++++++++
 tb/tb_ibus_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ibus_responder_pkg.sv
// Shared types for the instruction-bus responder: the common word type and the
// fetch-pipe state/request/response definitions.
package common;
    typedef logic [31:0] u32;
endpackage

package pipes;
    import common::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        RESP = 2'd3
    } ibus_state_t;

    typedef struct packed {
        u32 addr;
    } ibus_req_t;

    typedef struct packed {
        u32   data;
        logic err;
    } ibus_resp_t;

    localparam int unsigned CNT_W = 4;

    // Word-aligned and inside a memory of 'words' 32-bit entries.
    function automatic logic addr_legal(input u32 addr, input int unsigned words);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < words);
    endfunction
endpackage

// File: rtl/ibus_responder.sv
// Instruction-fetch responder: accepts one PC request at a time, reads an
// external synchronous ROM after a fixed wait, and returns the word or an error.
module ibus_responder
    import common::*;
    import pipes::*;
#(
    parameter  int unsigned LATENCY   = 2,
    parameter  int unsigned MEM_WORDS = 1024,
    localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  u32            req_addr,
    output logic          req_ready,
    input  logic          flush,
    output logic          resp_valid,
    output u32            resp_data,
    output logic          resp_err,
    input  logic          resp_ready,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    ibus_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    ibus_resp_t       resp_q, resp_d;
    ibus_req_t        req_s;
    logic             accept_s;
    logic             legal_s;

    assign req_s.addr = req_addr;
    assign legal_s    = addr_legal(req_s.addr, MEM_WORDS);
    assign accept_s   = req_valid && req_ready;

    // State, counter, latched address and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            resp_q  <= resp_d;
        end
    end

    // Next-state logic; flush in any busy state abandons the transaction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (legal_s) begin
                        addr_d  = req_s.addr[AW+1:2];
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end else begin
                        addr_d      = '0;
                        resp_d.data = 32'h0000_0000;
                        resp_d.err  = 1'b1;
                        state_d     = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = READ;
                end
            end
            READ: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    resp_d.data = mem_rdata;
                    resp_d.err  = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (resp_ready) begin
                    if (accept_s && legal_s) begin
                        addr_d  = req_s.addr[AW+1:2];
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end else if (accept_s) begin
                        addr_d      = '0;
                        resp_d.data = 32'h0000_0000;
                        resp_d.err  = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; flush gates both the ROM strobe and request acceptance.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 32'h0000_0000;
        resp_err   = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        case (state_q)
            IDLE: begin
                req_ready = !flush;
            end
            WAIT: begin
                if (!flush && (cnt_q == '0)) begin
                    mem_en   = 1'b1;
                    mem_addr = addr_q;
                end else begin
                    mem_en   = 1'b0;
                end
            end
            READ: begin
                req_ready = 1'b0;
            end
            RESP: begin
                req_ready  = resp_ready && !flush;
                resp_valid = 1'b1;
                resp_data  = resp_q.data;
                resp_err   = resp_q.err;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ibus_responder.sv
// Bench for ibus_responder: a behavioural ROM plus a transaction-age model that
// predicts every output cycle by cycle under directed and random stimulus.
module tb_ibus_responder;
    import common::*;

    localparam int unsigned LAT   = 2;
    localparam int unsigned WORDS = 1024;
    localparam int unsigned AW    = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    u32            req_addr;
    logic          req_ready;
    logic          flush;
    logic          resp_valid;
    u32            resp_data;
    logic          resp_err;
    logic          resp_ready;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;

    logic [31:0] rom [WORDS];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: one outstanding transaction, described by how many edges have
    // passed since the edge that accepted it.
    bit          m_busy  = 1'b0;
    int unsigned m_age   = 0;
    bit          m_legal = 1'b0;
    int unsigned m_idx   = 0;

    ibus_responder #(.LATENCY(LAT), .MEM_WORDS(WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the enable.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= rom[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp_v);
    endtask

    function automatic bit is_legal(input u32 a);
        return (a[1:0] == 2'b00) && ((a >> 2) < WORDS);
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input bit rv, input u32 ra, input bit rr, input bit fl);
        bit          e_rr, e_rv, e_err, e_men, responding, acc;
        u32          e_data;
        int unsigned e_maddr;
        req_valid  = rv;
        req_addr   = ra;
        resp_ready = rr;
        flush      = fl;
        @(negedge clk);
        e_rr = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_men = 1'b0; e_data = 32'h0; e_maddr = 0;
        // A legal request answers LATENCY+2 edges after acceptance (edge 1);
        // an illegal one answers right after the accepting edge.
        responding = m_busy && (!m_legal || (m_age >= LAT + 1));
        if (!m_busy) begin
            e_rr = !fl;
        end else if (!responding) begin
            e_men   = (m_age == LAT - 1) && !fl;
            e_maddr = e_men ? m_idx : 0;
        end else begin
            e_rv   = 1'b1;
            e_data = m_legal ? rom[m_idx] : 32'h0;
            e_err  = !m_legal;
            e_rr   = rr && !fl;
        end
        check_eq("req_ready",  32'(req_ready),  32'(e_rr));
        check_eq("resp_valid", 32'(resp_valid), 32'(e_rv));
        check_eq("resp_data",  resp_data,       e_data);
        check_eq("resp_err",   32'(resp_err),   32'(e_err));
        check_eq("mem_en",     32'(mem_en),     32'(e_men));
        check_eq("mem_addr",   32'(mem_addr),   e_maddr);
        acc = rv && e_rr;
        if (m_busy) begin
            if (fl || (responding && rr)) m_busy = 1'b0;
            else m_age++;
        end
        if (acc) begin
            m_busy  = 1'b1;
            m_age   = 0;
            m_legal = is_legal(ra);
            m_idx   = int'(ra[11:2]);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // Reset asserted mid-cycle; response and ROM outputs must clear at once.
    task automatic reset_now(input string tag);
        req_valid = 1'b0; resp_ready = 1'b1; flush = 1'b0;
        reset = 1'b0;
        #2;
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        check_eq({tag, "_resp_data"},  resp_data,       32'h0);
        check_eq({tag, "_resp_err"},   32'(resp_err),   32'h0);
        check_eq({tag, "_mem_en"},     32'(mem_en),     32'h0);
        check_eq({tag, "_mem_addr"},   32'(mem_addr),   32'h0);
        m_busy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        u32 a;
        for (int i = 0; i < int'(WORDS); i++) rom[i] = $urandom;
        rom[4] = 32'h2408_0005;
        reset = 1'b0; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0; flush = 1'b0;
        mem_rdata = 32'h0;
        #12;
        reset_now("por");

        // Legal fetch of word 4, then misaligned and out-of-range fetches.
        step(1'b1, 32'h0000_0010, 1'b1, 1'b0);
        idle(5);
        step(1'b1, 32'h0000_0013, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 32'h0000_1000, 1'b1, 1'b0);
        idle(2);

        // Response held for several cycles, then a back-to-back request.
        step(1'b1, 32'h0000_0020, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0024, 1'b1, 1'b0);
        idle(6);

        // Flush on the cycle the ROM strobe would fire.
        step(1'b1, 32'h0000_0030, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        idle(5);

        // Flush against a pending response, with a competing request.
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0044, 1'b1, 1'b1);
        idle(3);

        // Flush while idle must not disturb a following request.
        step(1'b1, 32'h0000_0048, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0048, 1'b1, 1'b0);
        idle(5);

        // Reset while the ROM read is in progress.
        step(1'b1, 32'h0000_0050, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        reset_now("rst_read");
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       a = {20'h0, 10'($urandom), 2'($urandom_range(1, 3))};
                1:       a = {18'($urandom_range(1, 262143)), 12'($urandom), 2'b00};
                default: a = {20'h0, 10'($urandom), 2'b00};
            endcase
            step(1'($urandom_range(0, 1)), a, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
